alu_serial_seq: RTL
===================

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width in bits (>= 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request strobe, sampled on rising clk.
REQ-005 SHALL have port: funct  input  6  operation code (AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010).
REQ-006 SHALL have ports: op_a, op_b  input  WIDTH  operands, sampled when start is accepted.
REQ-007 SHALL have ports: slice_a, slice_b, slice_c, slice_less  output  1  bit-slice A, B, carry-in and Less drives, all registered.
REQ-008 SHALL have port: slice_signal  output  6  bit-slice operation code, registered.
REQ-009 SHALL have ports: slice_sum, slice_cout  input  1  combinational bit-slice results.
REQ-010 SHALL have ports: busy  output  1  operation in progress; done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports: result  output  WIDTH; overflow, zero, err  output  1 each.

Function
REQ-012 SHALL implement states IDLE, RUN, SLT_CMP, SLT_OUT, FIN.
REQ-013 IDLE: start=1 SHALL latch funct/op_a/op_b, clear bit index and carry register, set busy=1.
REQ-014 On accept: AND/OR/ADD go to RUN with carry=0; SUB goes to RUN with carry=1; SLT goes to SLT_CMP with carry=1.
REQ-015 Unknown funct SHALL NOT enter RUN; next cycle done=1, err=1, result=0, overflow=0, zero=1, return to IDLE.
REQ-016 Each cycle in RUN/SLT_CMP/SLT_OUT, bit index k: slice_a=op_a[k], slice_b=op_b[k], slice_c=carry register, slice_signal=operation code; at the edge, slice_sum goes to result bit k and slice_cout to the carry register.
REQ-017 slice_signal SHALL be SUB (100010) during SLT_CMP and SLT (101010) during SLT_OUT; otherwise the latched funct.
REQ-018 k SHALL count 0..WIDTH-1 and wrap to 0 on each phase exit; no bit is skipped or repeated.
REQ-019 RUN: after bit WIDTH-1, overflow = carry-in XOR carry-out of bit WIDTH-1 for ADD/SUB, 0 for AND/OR; go to FIN.
REQ-020 SLT_CMP: SHALL discard sums except bit WIDTH-1; less = msb_sum XOR (carry-in(msb) XOR carry-out(msb)); go to SLT_OUT.
REQ-021 SLT_OUT: slice_less = less at k=0, 0 otherwise; slice_c=0; overflow=0.
REQ-022 FIN: done=1 for one cycle, busy=0, zero=(result==0), err=0; return to IDLE.
REQ-023 result/overflow/zero/err SHALL hold from done until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored (not queued); start in the FIN cycle is also ignored.
REQ-025 Latency start-accept to done: WIDTH+1 cycles (AND/OR/ADD/SUB), 2*WIDTH+1 (SLT), 1 (unknown).
REQ-026 In IDLE, slice_* drives SHALL be 0 and slice_signal 000000.

Reset
REQ-027 rst=1 SHALL immediately force IDLE; busy, done, err, overflow, slice_a/b/c/less = 0; slice_signal=000000; result=0; zero=1.
REQ-028 rst asserted mid-operation SHALL abort without a done pulse; the first start after rst release starts a fresh operation.

Verification (WIDTH=32, bench supplies a correct behavioural 1-bit slice)
REQ-029 ADD 0xFFFFFFFF+0x00000001 -> done after 33 cycles, result 0x00000000, zero=1, overflow=0.
REQ-030 SUB 0x80000000-0x00000001 -> result 0x7FFFFFFF, overflow=1; ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
REQ-031 SLT 0x80000000 vs 0x00000001 -> 65 cycles, result 0x00000001; SLT 5 vs 5 -> result 0, zero=1.
REQ-032 AND 0xF0F0F0F0, 0xFF00FF00 -> 0xF000F000; OR on the same operands -> 0xFFF0FFF0; overflow=0.
REQ-033 funct=000000 -> done one cycle after accept, err=1, result 0; start pulsed at cycles 5 and 20 of an ADD -> ignored, single done.
REQ-034 rst at cycle 10 of a SUB -> all outputs at reset values, no done; next ADD 2+3 -> result 5.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks an external 1-bit ALU slice across WIDTH bits,
// one bit per clock, for AND/OR/ADD/SUB and a two-pass SLT.
`timescale 1ns/1ps
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_c,
  output logic             slice_less,
  output logic [5:0]       slice_signal,
  input  logic             slice_sum,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, RUN, SLT_CMP, SLT_OUT, FIN} state_e;

  state_e           state_q, state_d;
  logic [5:0]       funct_q, funct_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             carry_q, carry_d;
  logic             less_q, less_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sa_q, sa_d, sb_q, sb_d, sc_q, sc_d, sl_q, sl_d;
  logic [5:0]       sig_q, sig_d;
  logic             k_last;

  assign k_last = (k_q == K_LAST);

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      funct_q  <= 6'b0;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      less_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      sc_q     <= 1'b0;
      sl_q     <= 1'b0;
      sig_q    <= 6'b0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      less_q   <= less_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sc_q     <= sc_d;
      sl_q     <= sl_d;
      sig_q    <= sig_d;
    end
  end

  // Next-state and next-output logic; slice drives are precomputed for the next cycle
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    carry_d  = carry_q;
    less_d   = less_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sa_d     = 1'b0;
    sb_d     = 1'b0;
    sc_d     = 1'b0;
    sl_d     = 1'b0;
    sig_d    = 6'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          funct_d  = funct;
          a_d      = op_a;
          b_d      = op_b;
          k_d      = '0;
          carry_d  = 1'b0;
          result_d = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          case (funct)
            F_AND, F_OR, F_ADD: state_d = RUN;
            F_SUB: begin
              state_d = RUN;
              carry_d = 1'b1;
            end
            F_SLT: begin
              state_d = SLT_CMP;
              carry_d = 1'b1;
            end
            default: begin
              state_d = FIN;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        result_d[k_q] = slice_sum;
        carry_d       = slice_cout;
        if (k_last) begin
          ovf_d   = ((funct_q == F_ADD) || (funct_q == F_SUB)) ? (carry_q ^ slice_cout) : 1'b0;
          k_d     = '0;
          state_d = FIN;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      SLT_CMP: begin
        // Subtraction pass: only the sign and overflow of the msb matter
        carry_d = slice_cout;
        if (k_last) begin
          less_d  = slice_sum ^ (carry_q ^ slice_cout);
          k_d     = '0;
          state_d = SLT_OUT;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      SLT_OUT: begin
        result_d[k_q] = slice_sum;
        carry_d       = slice_cout;
        if (k_last) begin
          ovf_d   = 1'b0;
          k_d     = '0;
          state_d = FIN;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == SLT_CMP) || (state_d == SLT_OUT);
    done_d = (state_d == FIN);
    if (state_d == FIN) zero_d = (result_d == '0);

    if (busy_d) begin
      sa_d = a_d[k_d];
      sb_d = b_d[k_d];
      sc_d = (state_d == SLT_OUT) ? 1'b0 : carry_d;
      sl_d = (state_d == SLT_OUT) && (k_d == '0) && less_d;
      case (state_d)
        SLT_CMP: sig_d = F_SUB;
        SLT_OUT: sig_d = F_SLT;
        default: sig_d = funct_d;
      endcase
    end
  end

  assign slice_a      = sa_q;
  assign slice_b      = sb_q;
  assign slice_c      = sc_q;
  assign slice_less   = sl_q;
  assign slice_signal = sig_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign overflow     = ovf_q;
  assign zero         = zero_q;
  assign err          = err_q;

endmodule
